// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and width helpers for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2
  } arbState_t;

  // Width of the grant index for a given channel count
  function automatic int gntWidth(input int numCh);
    return (numCh < 2) ? 1 : $clog2(numCh);
  endfunction

  // Width of a counter that must hold 0..maxCount (never narrower than 1)
  function automatic int cntWidth(input int maxCount);
    return (maxCount < 1) ? 1 : $clog2(maxCount + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_arbiter
// Description : Combinational round-robin pick. The search starts at iPtr and
//               wraps from NUM_CH-1 back to 0; the pointer register is owned
//               by the parent and advanced only when a grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]           iReq,
  input  logic [gntWidth(NUM_CH)-1:0] iPtr,
  output logic [gntWidth(NUM_CH)-1:0] oWinner,
  output logic                        oValid
);

  localparam int GW = gntWidth(NUM_CH);

  logic          wFound;
  logic [GW-1:0] wPick;

  // Two ordered passes: channels at/after the pointer first, then the wrapped ones
  always_comb begin
    wFound = 1'b0;
    wPick  = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!wFound && iReq[j] && (GW'(j) >= iPtr)) begin
        wFound = 1'b1;
        wPick  = GW'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!wFound && iReq[j] && (GW'(j) < iPtr)) begin
        wFound = 1'b1;
        wPick  = GW'(j);
      end
    end
    oWinner = wPick;
    oValid  = wFound;
  end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM controller host port among NUM_CH requesters
//               with a REQ/ACK handshake, round-robin arbitration, latched
//               commands, read-data capture, a guard interval after every
//               completion and an optional completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DSIZE        = 16,
  parameter int ASIZE        = 22,
  parameter int GUARD_CYCLES = 2,
  parameter int TIMEOUT      = 0
) (
  input  logic                      iCLK,
  input  logic                      iRST_n,
  input  logic [NUM_CH-1:0]         iCH_REQ,
  input  logic [NUM_CH-1:0]         iCH_WE,
  input  logic [NUM_CH*ASIZE-1:0]   iCH_ADDR,
  input  logic [NUM_CH*DSIZE-1:0]   iCH_DATA,
  output logic [NUM_CH-1:0]         oCH_ACK,
  output logic                      oCH_ERR,
  output logic [DSIZE-1:0]          oCH_RDATA,
  output logic [$clog2(NUM_CH)-1:0] oGNT,
  output logic                      oBUSY,
  output logic [ASIZE-1:0]          oSDR_ADDR,
  output logic [DSIZE-1:0]          oSDR_DATA,
  output logic                      oSDR_RD,
  output logic                      oSDR_WR,
  input  logic [DSIZE-1:0]          iSDR_DATA,
  input  logic                      iSDR_Done
);

  localparam int GW = $clog2(NUM_CH);
  localparam int TW = cntWidth(TIMEOUT);
  localparam int CW = cntWidth(GUARD_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);
  localparam bit GUARD_EN   = (GUARD_CYCLES > 0);
  // Timeout fires in the last of TIMEOUT strobe cycles, so the strobe is high exactly TIMEOUT cycles
  localparam logic [TW-1:0] TO_LAST    = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  // Guard state holds the ACK cycle plus GUARD_CYCLES further cycles
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES);

  typedef struct packed {
    logic             we;
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } sdrCmd_t;

  arbState_t         rState;
  arbState_t         wNextState;
  sdrCmd_t           rCmd;
  sdrCmd_t           wReqCmd;
  logic [GW-1:0]     rPtr;
  logic [GW-1:0]     rGnt;
  logic [GW-1:0]     wWinner;
  logic [GW-1:0]     wNextPtr;
  logic              wValid;
  logic              wGrant;
  logic              wComplete;
  logic              wAbort;
  logic [TW-1:0]     rToCnt;
  logic [CW-1:0]     rGuardCnt;
  logic              rSdrRd;
  logic              rSdrWr;
  logic              rErr;
  logic [NUM_CH-1:0] rAck;
  logic [DSIZE-1:0]  rRdata;

  sdram_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) uArbiter (
    .iReq    (iCH_REQ),
    .iPtr    (rPtr),
    .oWinner (wWinner),
    .oValid  (wValid)
  );

  // Winner's command fields and the pointer value that follows a grant to it
  always_comb begin
    wReqCmd.we   = iCH_WE[wWinner];
    wReqCmd.addr = iCH_ADDR[wWinner*ASIZE +: ASIZE];
    wReqCmd.data = iCH_DATA[wWinner*DSIZE +: DSIZE];
    wNextPtr     = (wWinner == GW'(NUM_CH - 1)) ? '0 : (wWinner + 1'b1);
  end

  // Next-state logic; Done wins over a timeout landing in the same cycle
  always_comb begin
    wNextState = rState;
    wGrant     = 1'b0;
    wComplete  = 1'b0;
    wAbort     = 1'b0;
    case (rState)
      ST_IDLE: begin
        if (wValid) begin
          wGrant     = 1'b1;
          wNextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (iSDR_Done) begin
          wComplete  = 1'b1;
          wNextState = GUARD_EN ? ST_GUARD : ST_IDLE;
        end else if (TIMEOUT_EN && (rToCnt == TO_LAST)) begin
          wAbort     = 1'b1;
          wNextState = GUARD_EN ? ST_GUARD : ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (rGuardCnt == GUARD_LAST) begin
          wNextState = ST_IDLE;
        end
      end
      default: wNextState = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rState <= ST_IDLE;
    end else begin
      rState <= wNextState;
    end
  end

  // Command latch, strobes, completion pulse, read capture and counters
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rCmd      <= '0;
      rPtr      <= '0;
      rGnt      <= '0;
      rSdrRd    <= 1'b0;
      rSdrWr    <= 1'b0;
      rAck      <= '0;
      rErr      <= 1'b0;
      rRdata    <= '0;
      rToCnt    <= '0;
      rGuardCnt <= '0;
    end else begin
      rAck <= '0;
      rErr <= 1'b0;
      if (wGrant) begin
        rCmd   <= wReqCmd;
        rGnt   <= wWinner;
        rPtr   <= wNextPtr;
        rSdrRd <= ~wReqCmd.we;
        rSdrWr <= wReqCmd.we;
        rToCnt <= '0;
      end
      if (TIMEOUT_EN && (rState == ST_ISSUE) && !wComplete && !wAbort) begin
        rToCnt <= rToCnt + 1'b1;
      end
      if (wComplete || wAbort) begin
        rSdrRd    <= 1'b0;
        rSdrWr    <= 1'b0;
        rAck      <= {{(NUM_CH-1){1'b0}}, 1'b1} << rGnt;
        rErr      <= wAbort;
        rGuardCnt <= '0;
      end
      if (wComplete && !rCmd.we) begin
        rRdata <= iSDR_DATA;
      end
      if ((rState == ST_GUARD) && (rGuardCnt != GUARD_LAST)) begin
        rGuardCnt <= rGuardCnt + 1'b1;
      end
    end
  end

  assign oCH_ACK   = rAck;
  assign oCH_ERR   = rErr;
  assign oCH_RDATA = rRdata;
  assign oGNT      = rGnt;
  assign oBUSY     = (rState != ST_IDLE);
  assign oSDR_ADDR = rCmd.addr;
  assign oSDR_DATA = rCmd.data;
  assign oSDR_RD   = rSdrRd;
  assign oSDR_WR   = rSdrWr;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Bench for sdram_port_arbiter. Instance A: GUARD 2 / TIMEOUT 8,
//               instance B: GUARD 0 / TIMEOUT 0; 'sel' picks the one observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 22;

  logic iCLK;
  logic iRST_n;
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addrBus;
  logic [N*DW-1:0] dataBus;
  logic [DW-1:0]   sdrData;
  logic            done;
  logic            sel;

  logic [N-1:0] ackA, ackB, oAck;
  logic errA, errB, oErr;
  logic [DW-1:0] rdataA, rdataB, oRdata;
  logic [1:0] gntA, gntB, oGnt;
  logic busyA, busyB, oBusy;
  logic [AW-1:0] addrA, addrB, oAddr;
  logic [DW-1:0] dataA, dataB, oData;
  logic rdA, rdB, oRd, wrA, wrB, oWr;

  int testCnt = 0;
  int failCnt = 0;
  int mPtr = 0;
  logic [DW-1:0] mRdata = '0;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  sdram_port_arbiter #(.NUM_CH(N), .DSIZE(DW), .ASIZE(AW), .GUARD_CYCLES(2), .TIMEOUT(8)) dutA (
    .iCLK(iCLK), .iRST_n(iRST_n), .iCH_REQ(req), .iCH_WE(we), .iCH_ADDR(addrBus),
    .iCH_DATA(dataBus), .oCH_ACK(ackA), .oCH_ERR(errA), .oCH_RDATA(rdataA), .oGNT(gntA),
    .oBUSY(busyA), .oSDR_ADDR(addrA), .oSDR_DATA(dataA), .oSDR_RD(rdA), .oSDR_WR(wrA),
    .iSDR_DATA(sdrData), .iSDR_Done(done));

  sdram_port_arbiter #(.NUM_CH(N), .DSIZE(DW), .ASIZE(AW), .GUARD_CYCLES(0), .TIMEOUT(0)) dutB (
    .iCLK(iCLK), .iRST_n(iRST_n), .iCH_REQ(req), .iCH_WE(we), .iCH_ADDR(addrBus),
    .iCH_DATA(dataBus), .oCH_ACK(ackB), .oCH_ERR(errB), .oCH_RDATA(rdataB), .oGNT(gntB),
    .oBUSY(busyB), .oSDR_ADDR(addrB), .oSDR_DATA(dataB), .oSDR_RD(rdB), .oSDR_WR(wrB),
    .iSDR_DATA(sdrData), .iSDR_Done(done));

  // Observe the selected instance
  always_comb begin
    oAck   = sel ? ackB   : ackA;
    oErr   = sel ? errB   : errA;
    oRdata = sel ? rdataB : rdataA;
    oGnt   = sel ? gntB   : gntA;
    oBusy  = sel ? busyB  : busyA;
    oAddr  = sel ? addrB  : addrA;
    oData  = sel ? dataB  : dataA;
    oRd    = sel ? rdB    : rdA;
    oWr    = sel ? wrB    : wrA;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin rule: first requester at or after ptr, wrapping
  function automatic int rrPick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  task automatic setReq(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1;
    we[k]  = w;
    addrBus[k*AW +: AW] = a;
    dataBus[k*DW +: DW] = d;
  endtask

  task automatic setRand(input int k);
    setReq(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_ack"},   64'(oAck),   64'd0);
    check({tag, "_err"},   64'(oErr),   64'd0);
    check({tag, "_rdata"}, 64'(oRdata), 64'd0);
    check({tag, "_gnt"},   64'(oGnt),   64'd0);
    check({tag, "_busy"},  64'(oBusy),  64'd0);
    check({tag, "_addr"},  64'(oAddr),  64'd0);
    check({tag, "_data"},  64'(oData),  64'd0);
    check({tag, "_rd"},    64'(oRd),    64'd0);
    check({tag, "_wr"},    64'(oWr),    64'd0);
  endtask

  // One access on instance A, entered at a negedge of an IDLE cycle with
  // requests pending. d = cycle of strobe in which Done is raised (0: never).
  task automatic runTxn(input int d, input logic [DW-1:0] rv, input bit reraise, output int obsG);
    int win;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    logic eWe;
    win   = rrPick(req, mPtr);
    mPtr  = (win + 1) % N;
    eAddr = addrBus[win*AW +: AW];
    eData = dataBus[win*DW +: DW];
    eWe   = we[win];
    @(negedge iCLK);
    done = 1'b0;
    obsG = int'(oGnt);
    check("grant_idx", 64'(oGnt), 64'(win));
    check("busy_issue", 64'(oBusy), 64'd1);
    addrBus[win*AW +: AW] = ~eAddr;
    dataBus[win*DW +: DW] = ~eData;
    we[win] = ~eWe;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge iCLK);
      check("strobe_rd", 64'(oRd), 64'(!eWe));
      check("strobe_wr", 64'(oWr), 64'(eWe));
      check("latched_addr", 64'(oAddr), 64'(eAddr));
      check("latched_data", 64'(oData), 64'(eData));
      check("ack_quiet", 64'(oAck), 64'd0);
      if (k == d) begin
        done = 1'b1;
        sdrData = rv;
        break;
      end
    end
    @(negedge iCLK);
    done = 1'b0;
    sdrData = DW'($urandom);
    if (d != 0 && !eWe) mRdata = rv;
    check("ack_onehot", 64'(oAck), 64'(1) << win);
    check("ack_err", 64'(oErr), 64'(d == 0));
    check("rdata", 64'(oRdata), 64'(mRdata));
    check("strobe_off", 64'({oRd, oWr}), 64'd0);
    check("busy_ack", 64'(oBusy), 64'd1);
    @(negedge iCLK);
    req[win] = 1'b0;
    done = 1'($urandom_range(0, 1));
    check("busy_guard1", 64'(oBusy), 64'd1);
    check("ack_single", 64'(oAck), 64'd0);
    @(negedge iCLK);
    if (reraise) setRand(win);
    done = 1'($urandom_range(0, 1));
    check("busy_guard2", 64'(oBusy), 64'd1);
    @(negedge iCLK);
    done = 1'($urandom_range(0, 1));
    check("busy_idle", 64'(oBusy), 64'd0);
    check("strobe_idle", 64'({oRd, oWr}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int order [5];
    logic [DW-1:0] rvB;
    order = '{0, 1, 2, 3, 0};
    sel = 1'b0; iRST_n = 1'b0; req = '0; we = '0; addrBus = '0; dataBus = '0;
    sdrData = '0; done = 1'b0;
    repeat (2) @(negedge iCLK);
    checkAllZero("reset");
    iRST_n = 1'b1;

    // Single read on ch1, Done raised in strobe cycle 6
    setReq(1, 1'b0, 22'h001234, 16'h1111);
    runTxn(6, 16'hBEEF, 1'b0, g);
    check("single_read_data", 64'(oRdata), 64'hBEEF);

    // Write with input changes during ISSUE
    setReq(2, 1'b1, 22'h3FFFFF, 16'h5A5A);
    runTxn(4, 16'h7777, 1'b0, g);
    check("write_keeps_rdata", 64'(oRdata), 64'hBEEF);

    // Timeout, then a normal access
    setReq(3, 1'b0, 22'h000042, 16'h0);
    runTxn(0, 16'hDEAD, 1'b0, g);
    setReq(0, 1'b0, 22'h000100, 16'h0);
    runTxn(3, 16'h4321, 1'b0, g);

    // Reset while a write is in flight
    done = 1'b0;
    setReq(2, 1'b1, 22'h00ABCD, 16'hCAFE);
    @(negedge iCLK);
    check("pre_reset_wr", 64'(oWr), 64'd1);
    #2 iRST_n = 1'b0;
    #1 checkAllZero("async_reset");
    repeat (2) @(negedge iCLK);
    check("reset_no_ack", 64'(oAck), 64'd0);
    iRST_n = 1'b1;
    mPtr = 0; mRdata = '0;

    // Contention: all channels requesting, round-robin order from pointer 0
    for (int k = 0; k < N; k++) setRand(k);
    for (int i = 0; i < 5; i++) begin
      runTxn($urandom_range(1, 5), DW'($urandom), 1'b1, g);
      check("rr_order", 64'(g), 64'(order[i]));
    end

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      if (req == '0) setRand($urandom_range(0, N - 1));
      for (int k = 0; k < N; k++) if (!req[k] && $urandom_range(0, 2) == 0) setRand(k);
      runTxn($urandom_range(0, 8), DW'($urandom), 1'($urandom_range(0, 1)), g);
    end

    // Instance B: no guard, no timeout
    sel = 1'b1; done = 1'b0; req = '0; iRST_n = 1'b0;
    @(negedge iCLK);
    iRST_n = 1'b1;
    done = 1'b1;
    repeat (3) begin
      @(negedge iCLK);
      check("b_spurious_busy", 64'(oBusy), 64'd0);
      check("b_spurious_strobe", 64'({oRd, oWr, oAck}), 64'd0);
    end
    done = 1'b0;
    rvB = 16'h9A3C;
    setReq(0, 1'b0, 22'h011111, 16'h0001);
    setReq(1, 1'b1, 22'h022222, 16'h0002);
    @(negedge iCLK);
    check("b_gnt0", 64'(oGnt), 64'd0);
    check("b_rd0", 64'(oRd), 64'd1);
    done = 1'b1; sdrData = rvB;
    @(negedge iCLK);
    done = 1'b0;
    check("b_ack0", 64'(oAck), 64'b0001);
    check("b_rdata0", 64'(oRdata), 64'(rvB));
    check("b_busy_ack", 64'(oBusy), 64'd0);
    @(negedge iCLK);
    req[0] = 1'b0;
    check("b_b2b_gnt", 64'(oGnt), 64'd1);
    check("b_b2b_wr", 64'(oWr), 64'd1);
    check("b_b2b_addr", 64'(oAddr), 64'h022222);
    check("b_b2b_data", 64'(oData), 64'h0002);
    done = 1'b1;
    @(negedge iCLK);
    done = 1'b0;
    check("b_ack1", 64'(oAck), 64'b0010);
    check("b_err1", 64'(oErr), 64'd0);
    check("b_rdata_kept", 64'(oRdata), 64'(rvB));
    @(negedge iCLK);
    req[1] = 1'b0;
    check("b_regrant_gnt", 64'(oGnt), 64'd1);
    check("b_regrant_wr", 64'(oWr), 64'd1);
    check("b_regrant_busy", 64'(oBusy), 64'd1);
    repeat (20) @(negedge iCLK);
    check("b_no_timeout_wr", 64'(oWr), 64'd1);
    check("b_no_timeout_ack", 64'(oAck), 64'd0);
    done = 1'b1;
    @(negedge iCLK);
    done = 1'b0;
    check("b_ack_late", 64'(oAck), 64'b0010);
    check("b_ack_late_err", 64'(oErr), 64'd0);
    check("b_late_wr_off", 64'(oWr), 64'd0);
    @(negedge iCLK);
    check("b_final_busy", 64'(oBusy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
`default_nettype wire
